// File: rtl/branch_resolve_ctrl.sv
// Branch resolution between Fetch and Decode: IF/ID latch, predictor
// update strobes, fetch redirect, wrong-path squash and perf counters.
module branch_resolve_ctrl #(
    parameter int PC_W  = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [PC_W-1:0]  PC_curr,
    input  logic [1:0]       prediction,
    input  logic [PC_W-1:0]  predicted_target,
    input  logic             is_branch,
    input  logic             actual_taken,
    input  logic [PC_W-1:0]  actual_target,
    output logic [PC_W-1:0]  IF_ID_PC_curr,
    output logic [1:0]       IF_ID_prediction,
    output logic [PC_W-1:0]  IF_ID_predicted_target,
    output logic             IF_ID_valid,
    output logic             wen_BHT,
    output logic             wen_BTB,
    output logic             update_PC,
    output logic [PC_W-1:0]  redirect_target,
    output logic             flush,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [1:0]       pred_q, pred_d;
    logic [PC_W-1:0]  tgt_q, tgt_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] bcnt_q, bcnt_d;
    logic [CNT_W-1:0] mcnt_q, mcnt_d;
    logic [CNT_W-1:0] scnt_q, scnt_d;

    logic resolve;
    logic mispred;
    logic tgt_bad;

    always_comb begin
        resolve = valid_q & is_branch & ~stall & ~rst
                & (state_q == RUN);
        mispred = pred_q[1] != actual_taken;
        tgt_bad = tgt_q != actual_target;
        wen_BHT = resolve;
        wen_BTB = resolve & (actual_taken | tgt_bad);
        update_PC = resolve
                  & ((actual_taken & (mispred | tgt_bad))
                  | (~actual_taken & pred_q[1]));
        flush = update_PC;
        redirect_target = '0;
        if (update_PC) begin
            redirect_target = actual_taken ? actual_target
                                           : pc_q + PC_W'(2);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:   if (update_PC) state_d = FLUSH;
            FLUSH: if (!stall) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        pc_d    = pc_q;
        pred_d  = pred_q;
        tgt_d   = tgt_q;
        valid_d = valid_q;
        if (!stall) begin
            if (flush) begin
                pc_d    = '0;
                pred_d  = 2'b00;
                tgt_d   = '0;
                valid_d = 1'b0;
            end else begin
                pc_d    = PC_curr;
                pred_d  = prediction;
                tgt_d   = predicted_target;
                valid_d = 1'b1;
            end
        end
    end

    // Saturating: an all-ones counter holds instead of wrapping
    always_comb begin
        bcnt_d = bcnt_q;
        mcnt_d = mcnt_q;
        scnt_d = scnt_q;
        if (resolve && bcnt_q != '1) bcnt_d = bcnt_q + 1'b1;
        if (update_PC && mcnt_q != '1) mcnt_d = mcnt_q + 1'b1;
        if (stall && scnt_q != '1) scnt_d = scnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= '0;
            pred_q  <= 2'b00;
            tgt_q   <= '0;
            valid_q <= 1'b0;
            bcnt_q  <= '0;
            mcnt_q  <= '0;
            scnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pred_q  <= pred_d;
            tgt_q   <= tgt_d;
            valid_q <= valid_d;
            bcnt_q  <= bcnt_d;
            mcnt_q  <= mcnt_d;
            scnt_q  <= scnt_d;
        end
    end

    assign IF_ID_PC_curr          = pc_q;
    assign IF_ID_prediction       = pred_q;
    assign IF_ID_predicted_target = tgt_q;
    assign IF_ID_valid            = valid_q;
    assign branch_count           = bcnt_q;
    assign mispredict_count       = mcnt_q;
    assign stall_count            = scnt_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Scoreboard bench for branch_resolve_ctrl: driver queues expected
// outputs per cycle, monitor pops and compares on the falling edge.
module tb_branch_resolve_ctrl;

    localparam int PC_W  = 16;
    localparam int CNT_W = 4;

    typedef struct {
        string            nm;
        logic [15:0]      pc;
        logic [1:0]       pr;
        logic [15:0]      pt;
        logic             v;
        logic             bht;
        logic             btb;
        logic             upd;
        logic [15:0]      rt;
        logic [CNT_W-1:0] bc;
        logic [CNT_W-1:0] mc;
        logic [CNT_W-1:0] sc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             stall;
    logic [PC_W-1:0]  PC_curr;
    logic [1:0]       prediction;
    logic [PC_W-1:0]  predicted_target;
    logic             is_branch;
    logic             actual_taken;
    logic [PC_W-1:0]  actual_target;
    logic [PC_W-1:0]  IF_ID_PC_curr;
    logic [1:0]       IF_ID_prediction;
    logic [PC_W-1:0]  IF_ID_predicted_target;
    logic             IF_ID_valid;
    logic             wen_BHT;
    logic             wen_BTB;
    logic             update_PC;
    logic [PC_W-1:0]  redirect_target;
    logic             flush;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] mispredict_count;
    logic [CNT_W-1:0] stall_count;

    exp_t q[$];
    int   ncmp = 0;
    int   nbad = 0;

    always #5 clk = ~clk;

    branch_resolve_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .stall                  (stall),
        .PC_curr                (PC_curr),
        .prediction             (prediction),
        .predicted_target       (predicted_target),
        .is_branch              (is_branch),
        .actual_taken           (actual_taken),
        .actual_target          (actual_target),
        .IF_ID_PC_curr          (IF_ID_PC_curr),
        .IF_ID_prediction       (IF_ID_prediction),
        .IF_ID_predicted_target (IF_ID_predicted_target),
        .IF_ID_valid            (IF_ID_valid),
        .wen_BHT                (wen_BHT),
        .wen_BTB                (wen_BTB),
        .update_PC              (update_PC),
        .redirect_target        (redirect_target),
        .flush                  (flush),
        .branch_count           (branch_count),
        .mispredict_count       (mispredict_count),
        .stall_count            (stall_count)
    );

    task automatic chk(input string nm, input string f,
                       input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nbad++;
            $display("FAIL %s.%s got=%0h want=%0h", nm, f, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk(e.nm, "pc", int'(IF_ID_PC_curr), int'(e.pc));
            chk(e.nm, "pred", int'(IF_ID_prediction), int'(e.pr));
            chk(e.nm, "ptgt", int'(IF_ID_predicted_target), int'(e.pt));
            chk(e.nm, "valid", int'(IF_ID_valid), int'(e.v));
            chk(e.nm, "bht", int'(wen_BHT), int'(e.bht));
            chk(e.nm, "btb", int'(wen_BTB), int'(e.btb));
            chk(e.nm, "upd", int'(update_PC), int'(e.upd));
            chk(e.nm, "flush", int'(flush), int'(e.upd));
            chk(e.nm, "rt", int'(redirect_target), int'(e.rt));
            chk(e.nm, "bcnt", int'(branch_count), int'(e.bc));
            chk(e.nm, "mcnt", int'(mispredict_count), int'(e.mc));
            chk(e.nm, "scnt", int'(stall_count), int'(e.sc));
        end
    end

    function automatic logic [CNT_W-1:0] sat(input int v);
        return (v > 15) ? 4'hF : CNT_W'(v);
    endfunction

    task automatic cyc(
        input string nm, input logic r, input logic s,
        input logic [15:0] pc, input logic [1:0] pr,
        input logic [15:0] pt, input logic ib,
        input logic at, input logic [15:0] atg,
        input logic [15:0] epc, input logic [1:0] epr,
        input logic [15:0] ept, input logic ev,
        input logic ebht, input logic ebtb, input logic eupd,
        input logic [15:0] ert, input logic [CNT_W-1:0] ebc,
        input logic [CNT_W-1:0] emc, input logic [CNT_W-1:0] esc);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        stall = s;
        PC_curr = pc;
        prediction = pr;
        predicted_target = pt;
        is_branch = ib;
        actual_taken = at;
        actual_target = atg;
        e.nm = nm;
        e.pc = epc;
        e.pr = epr;
        e.pt = ept;
        e.v = ev;
        e.bht = ebht;
        e.btb = ebtb;
        e.upd = eupd;
        e.rt = ert;
        e.bc = ebc;
        e.mc = emc;
        e.sc = esc;
        q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        PC_curr = '0;
        prediction = 2'b00;
        predicted_target = '0;
        is_branch = 1'b0;
        actual_taken = 1'b0;
        actual_target = '0;
        repeat (2) @(posedge clk);

        cyc("rst", 1, 0, 16'h0, 2'b00, 16'h0, 0, 0, 16'h0,
            16'h0, 2'b00, 16'h0, 0, 0, 0, 0, 16'h0, 0, 0, 0);
        cyc("t1a", 0, 0, 16'h0002, 2'b01, 16'h0, 0, 0, 16'h0,
            16'h0, 2'b00, 16'h0, 0, 0, 0, 0, 16'h0, 0, 0, 0);
        cyc("t1b", 0, 0, 16'h0004, 2'b00, 16'h0, 0, 0, 16'h0,
            16'h0002, 2'b01, 16'h0, 1, 0, 0, 0, 16'h0, 0, 0, 0);
        cyc("t2", 0, 0, 16'h0006, 2'b00, 16'h0, 1, 1, 16'h0010,
            16'h0004, 2'b00, 16'h0, 1, 1, 1, 1, 16'h0010, 0, 0, 0);
        cyc("t2f", 0, 0, 16'h0004, 2'b10, 16'h0010, 1, 1, 16'h0020,
            16'h0, 2'b00, 16'h0, 0, 0, 0, 0, 16'h0, 1, 1, 0);
        cyc("t3", 0, 0, 16'h0006, 2'b00, 16'h0, 1, 0, 16'h0010,
            16'h0004, 2'b10, 16'h0010, 1, 1, 0, 1, 16'h0006, 1, 1, 0);
        cyc("t3f", 0, 0, 16'h0008, 2'b11, 16'h0010, 0, 0, 16'h0,
            16'h0, 2'b00, 16'h0, 0, 0, 0, 0, 16'h0, 2, 2, 0);
        cyc("t4", 0, 0, 16'h000A, 2'b01, 16'h0040, 1, 1, 16'h0010,
            16'h0008, 2'b11, 16'h0010, 1, 1, 1, 0, 16'h0, 2, 2, 0);
        cyc("t5s0", 0, 1, 16'h000C, 2'b00, 16'h0, 1, 1, 16'h0030,
            16'h000A, 2'b01, 16'h0040, 1, 0, 0, 0, 16'h0, 3, 2, 0);
        cyc("t5s1", 0, 1, 16'h000C, 2'b00, 16'h0, 1, 1, 16'h0030,
            16'h000A, 2'b01, 16'h0040, 1, 0, 0, 0, 16'h0, 3, 2, 1);
        cyc("t5s2", 0, 1, 16'h000C, 2'b00, 16'h0, 1, 1, 16'h0030,
            16'h000A, 2'b01, 16'h0040, 1, 0, 0, 0, 16'h0, 3, 2, 2);
        cyc("t5r", 0, 0, 16'h000C, 2'b00, 16'h0, 1, 0, 16'h0040,
            16'h000A, 2'b01, 16'h0040, 1, 1, 0, 0, 16'h0, 3, 2, 3);
        cyc("t5n", 0, 0, 16'h0020, 2'b00, 16'h0, 0, 0, 16'h0,
            16'h000C, 2'b00, 16'h0, 1, 0, 0, 0, 16'h0, 4, 2, 3);

        for (int i = 0; i < 15; i++) begin
            cyc("satA", 0, 0, 16'h0200, 2'b00, 16'h0, 1, 1, 16'h0100,
                16'h0020, 2'b00, 16'h0, 1, 1, 1, 1, 16'h0100,
                sat(4 + i), sat(2 + i), sat(3 + i));
            if (i < 14) begin
                cyc("satB1", 0, 1, 16'h0300, 2'b11, 16'h0300,
                    1, 1, 16'h0100,
                    16'h0, 2'b00, 16'h0, 0, 0, 0, 0, 16'h0,
                    sat(5 + i), sat(3 + i), sat(3 + i));
                cyc("satB2", 0, 0, 16'h0020, 2'b00, 16'h0,
                    1, 1, 16'h0100,
                    16'h0, 2'b00, 16'h0, 0, 0, 0, 0, 16'h0,
                    sat(5 + i), sat(3 + i), sat(4 + i));
            end
        end

        cyc("t6rst", 1, 1, 16'h0, 2'b00, 16'h0, 1, 1, 16'h0100,
            16'h0, 2'b00, 16'h0, 0, 0, 0, 0, 16'h0, 15, 15, 15);
        cyc("t6clr", 0, 0, 16'h0030, 2'b00, 16'h0, 0, 0, 16'h0,
            16'h0, 2'b00, 16'h0, 0, 0, 0, 0, 16'h0, 0, 0, 0);
        cyc("t6run", 0, 0, 16'hFFFE, 2'b10, 16'h1234, 1, 1, 16'h0050,
            16'h0030, 2'b00, 16'h0, 1, 1, 1, 1, 16'h0050, 0, 0, 0);
        cyc("wrapf", 0, 0, 16'hFFFE, 2'b10, 16'h1234, 0, 0, 16'h0,
            16'h0, 2'b00, 16'h0, 0, 0, 0, 0, 16'h0, 1, 1, 0);
        cyc("wrap", 0, 0, 16'h0, 2'b00, 16'h0, 1, 0, 16'h1234,
            16'hFFFE, 2'b10, 16'h1234, 1, 1, 0, 1, 16'h0000, 1, 1, 0);
        cyc("wrapn", 0, 0, 16'h0, 2'b00, 16'h0, 0, 0, 16'h0,
            16'h0, 2'b00, 16'h0, 0, 0, 0, 0, 16'h0, 2, 2, 0);

        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            nbad++;
            $display("FAIL drain left=%0d want=0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nbad);
        $finish;
    end

endmodule
